// File: rtl/hall_pkg.sv
// Shared hall sensor definitions: code-to-sector mapping, tracker states, fault codes.
package hall_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_INVALID = 2'b01;
    localparam logic [1:0] FLT_SKIP    = 2'b10;
    localparam logic [1:0] FLT_CFG     = 2'b11;

    // Hall code {W,V,U} for each electrical sector.
    localparam logic [2:0] HALL_S0 = 3'b001;
    localparam logic [2:0] HALL_S1 = 3'b011;
    localparam logic [2:0] HALL_S2 = 3'b010;
    localparam logic [2:0] HALL_S3 = 3'b110;
    localparam logic [2:0] HALL_S4 = 3'b100;
    localparam logic [2:0] HALL_S5 = 3'b101;

    typedef struct packed {
        logic       valid;
        logic [2:0] sec;
    } hall_dec_t;

    function automatic hall_dec_t hall_decode(input logic [2:0] h);
        hall_dec_t d;
        d.valid = 1'b1;
        d.sec   = 3'd0;
        case (h)
            HALL_S0: d.sec = 3'd0;
            HALL_S1: d.sec = 3'd1;
            HALL_S2: d.sec = 3'd2;
            HALL_S3: d.sec = 3'd3;
            HALL_S4: d.sec = 3'd4;
            HALL_S5: d.sec = 3'd5;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

    // (to - from) mod 6, both operands in 0..5.
    function automatic logic [2:0] sector_delta(input logic [2:0] from_s, input logic [2:0] to_s);
        logic [3:0] d;
        d = {1'b0, to_s} + 4'd6 - {1'b0, from_s};
        if (d >= 4'd6) d = d - 4'd6;
        return d[2:0];
    endfunction

endpackage

// File: rtl/hall_period_timer.sv
// Transition period counter with period latch, one-cycle update pulse and stall detect.
module hall_period_timer
    import hall_pkg::*;
#(
    parameter int PERIOD_W     = 24,
    parameter int STALL_CYCLES = 5000000
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                run,
    input  logic                step,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stall
);

    localparam logic [PERIOD_W:0] STALL_TH = (PERIOD_W+1)'(STALL_CYCLES);

    logic [PERIOD_W-1:0] timer_q;
    logic [PERIOD_W-1:0] period_q;
    logic                pv_q;
    logic                stall_q;
    logic                armed_q;
    logic [PERIOD_W:0]   timer_inc;
    logic                timer_at_max;
    logic [PERIOD_W-1:0] period_sat;

    assign timer_inc    = {1'b0, timer_q} + (PERIOD_W+1)'(1);
    assign timer_at_max = &timer_q;
    assign period_sat   = timer_inc[PERIOD_W] ? {PERIOD_W{1'b1}} : timer_inc[PERIOD_W-1:0];

    // armed_q is low until one step has been seen since entering TRACK or since a
    // stall, so the first interval measured is always a complete one.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            timer_q  <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            stall_q  <= 1'b0;
            armed_q  <= 1'b0;
        end else if (!run) begin
            timer_q  <= '0;
            pv_q     <= 1'b0;
            stall_q  <= 1'b0;
            armed_q  <= 1'b0;
        end else if (step) begin
            timer_q  <= '0;
            stall_q  <= 1'b0;
            armed_q  <= 1'b1;
            pv_q     <= armed_q;
            if (armed_q) period_q <= period_sat;
        end else begin
            pv_q <= 1'b0;
            if (!timer_at_max) timer_q <= timer_inc[PERIOD_W-1:0];
            if (timer_inc >= STALL_TH) begin
                stall_q <= 1'b1;
                armed_q <= 1'b0;
            end
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign stall        = stall_q;

endmodule

// File: rtl/hall_sector_tracker.sv
// Hall UVW sector decoder with direction, position, period, stall and fault tracking.
// Optional HALL_GLITCH_FILTER_EN: require two identical samples before accepting a code.
module hall_sector_tracker
    import hall_pkg::*;
#(
    parameter int PERIOD_W     = 24,
    parameter int STALL_CYCLES = 5000000,
    parameter int POS_W        = 16
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [7:0]          uvw_data,
    input  logic [7:0]          encoder_error_data,
    input  logic                clr_fault,
    output logic [2:0]          sector,
    output logic                sector_valid,
    output logic                dir,
    output logic [POS_W-1:0]    pos_count,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stall,
    output logic                hall_fault,
    output logic [1:0]          fault_code
);

    logic [2:0]       h;
    logic             cfg_err;
    hall_dec_t        hdec;
    logic             acc;
    logic             unused_in;

    state_e           state_q, state_d;
    logic [1:0]       code_q, code_d;
    logic [2:0]       sector_q, sector_d;
    logic             dir_q, dir_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             inv_q;
    logic             step;
    logic [2:0]       delta;

    assign h         = uvw_data[2:0];
    assign cfg_err   = encoder_error_data[0];
    assign hdec      = hall_decode(h);
    assign unused_in = ^{uvw_data[7:3], encoder_error_data[7:1]};

`ifdef HALL_GLITCH_FILTER_EN
    logic [2:0] h_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) h_q <= 3'b000;
        else           h_q <= h;
    end

    assign acc = hdec.valid && (h == h_q);
`else
    assign acc = hdec.valid;
`endif

    assign delta = sector_delta(sector_q, hdec.sec);

    // Invalid-code history: only an invalid code on two consecutive cycles faults.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) inv_q <= 1'b0;
        else           inv_q <= (state_q != ST_FAULT) && !hdec.valid;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_INIT;
            code_q   <= FLT_NONE;
            sector_q <= 3'd0;
            dir_q    <= 1'b0;
            pos_q    <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            sector_q <= sector_d;
            dir_q    <= dir_d;
            pos_q    <= pos_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        sector_d = sector_q;
        dir_d    = dir_q;
        pos_d    = pos_q;
        step     = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (acc) begin
                    sector_d = hdec.sec;
                    state_d  = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (acc && (hdec.sec != sector_q)) begin
                    if (delta == 3'd1) begin
                        step     = 1'b1;
                        sector_d = hdec.sec;
                        dir_d    = 1'b0;
                        pos_d    = pos_q + POS_W'(1);
                    end else if (delta == 3'd5) begin
                        step     = 1'b1;
                        sector_d = hdec.sec;
                        dir_d    = 1'b1;
                        pos_d    = pos_q - POS_W'(1);
                    end else begin
                        state_d = ST_FAULT;
                        code_d  = FLT_SKIP;
                    end
                end
            end
            ST_FAULT: begin
                if (clr_fault && !cfg_err) begin
                    state_d = ST_INIT;
                    code_d  = FLT_NONE;
                end
            end
            default: begin
                state_d = ST_INIT;
                code_d  = FLT_NONE;
            end
        endcase

        // Fault entry overrides; config error outranks everything and freezes the
        // sector/position as they were before this cycle.
        if (state_q != ST_FAULT) begin
            if (!hdec.valid && inv_q) begin
                state_d = ST_FAULT;
                code_d  = FLT_INVALID;
            end
            if (cfg_err) begin
                state_d  = ST_FAULT;
                code_d   = FLT_CFG;
                step     = 1'b0;
                sector_d = sector_q;
                dir_d    = dir_q;
                pos_d    = pos_q;
            end
        end
    end

    hall_period_timer #(
        .PERIOD_W     (PERIOD_W),
        .STALL_CYCLES (STALL_CYCLES)
    ) u_timer (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .run          (state_q == ST_TRACK),
        .step         (step),
        .period       (period),
        .period_valid (period_valid),
        .stall        (stall)
    );

    assign sector       = sector_q;
    assign sector_valid = (state_q == ST_TRACK);
    assign dir          = dir_q;
    assign pos_count    = pos_q;
    assign hall_fault   = (state_q == ST_FAULT);
    assign fault_code   = code_q;

endmodule

// File: doc/hall_sector_tracker.md
Name: hall_sector_tracker

Overview:
- Consumes the registered hall-state byte (uvw_data) and the encoder configuration error byte (encoder_error_data) from the encoder input stage.
- Decodes the 3-bit UVW hall code into a 0..5 electrical sector and tracks rotation direction and signed position.
- Measures the period between sector transitions, and detects stall, invalid codes and skipped sectors.
- Feeds the commutation and speed-loop logic downstream.

Parameters:
- PERIOD_W, 24, width of the transition period counter and the period output.
- STALL_CYCLES, 5000000, cycles without an accepted transition before stall asserts (100 ms at 50 MHz).
- POS_W, 16, width of the signed sector position counter.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- uvw_data  input  8  [0]=U, [1]=V, [2]=W hall state; [7:3] ignored.
- encoder_error_data  input  8  [0]=encoder config error; [7:1] ignored.
- clr_fault  input  1  synchronous clear of sticky faults; level sampled each cycle.
- sector  output  3  current sector 0..5.
- sector_valid  output  1  sector and dir are meaningful.
- dir  output  1  0 = forward (sector+1), 1 = reverse.
- pos_count  output  POS_W  signed sector count; +1 per forward step, -1 per reverse step; wraps two's-complement.
- period  output  PERIOD_W  clock cycles between the last two accepted transitions.
- period_valid  output  1  one-cycle pulse when period updates.
- stall  output  1  no accepted transition for STALL_CYCLES cycles.
- hall_fault  output  1  sticky fault flag.
- fault_code  output  2  01 = invalid code, 10 = skipped sector, 11 = config error; 00 = none. The first fault wins.

Behaviour:
- Reset: sector=0, sector_valid=0, dir=0, pos_count=0, period=0, period_valid=0, stall=0, hall_fault=0, fault_code=00, FSM=INIT, timer=0.
- Hall code H = {W,V,U}. Mapping: 001→0, 011→1, 010→2, 110→3, 100→4, 101→5. Codes 000 and 111 are invalid.
- Latency: a new valid H present at the input on cycle n appears on sector at cycle n+1 (without the optional feature).
- FSM states: INIT, TRACK, FAULT.
- INIT:
  - First valid H loads sector and sets sector_valid=1, then moves to TRACK.
  - No period_valid pulse and no pos_count change on this entry.
- TRACK, per accepted H change, with delta = (new − old) mod 6:
  - delta 1: forward step; dir=0, pos_count+1.
  - delta 5: reverse step; dir=1, pos_count−1.
  - delta 2, 3 or 4: skipped sector; go to FAULT with code 10.
  - Same code: no action.
- Invalid H for 2 consecutive cycles in INIT or TRACK goes to FAULT with code 01. A single-cycle invalid H is ignored and the sector is held.
- encoder_error_data[0]=1 in any state goes to FAULT with code 11. This takes priority over the other faults on the same cycle.
- FAULT:
  - hall_fault=1, sector_valid=0; sector, pos_count and period hold.
  - clr_fault=1 with the config error deasserted returns to INIT and clears hall_fault/fault_code.
  - clr_fault while the config error is still asserted is ignored.
- Period timer:
  - Increments every cycle in TRACK and saturates at 2^PERIOD_W−1.
  - On an accepted step: period = timer+1, timer=0, period_valid pulses.
  - Exception: the first step after INIT or after a stall loads the timer only (no pulse).
  - Timer is held at 0 in INIT and FAULT.
- Stall:
  - Asserts on the cycle timer+1 reaches STALL_CYCLES and stays asserted.
  - Cleared by the next accepted step, which gives no period_valid.
  - stall is forced to 0 in INIT and FAULT.
- Simultaneous step and stall threshold on the same cycle: the step wins; stall stays 0 and period=STALL_CYCLES.
- Reset mid-operation restores all reset values immediately (asynchronous reset).

Optional Feature:
- Macro: HALL_GLITCH_FILTER_EN.
- Defined: a changed valid H must be identical on 2 consecutive samples before acceptance, so sector latency is 2 cycles. A 1-cycle excursion to another valid code is ignored.
- Undefined: a valid H is accepted on its first sample with 1-cycle latency.
- Invalid-code handling is identical in both cases.

Decomposition:
- Shared package hall_pkg holds:
  - hall-code-to-sector constants;
  - state enum (INIT/TRACK/FAULT);
  - fault_code constants (FLT_NONE, FLT_INVALID, FLT_SKIP, FLT_CFG).
- One sub-module, hall_period_timer, contains the saturating counter, period latch, period_valid pulse and stall compare. It is driven by step/clear strobes from the FSM.

Test Plan:
- Reset, then H sequence 001,011,010,110,100,101,001, each held 100 cycles → sector 0..5,0; dir=0; pos_count=6; period=100 on 5 pulses (none on the first step).
- From sector 3 (110), apply 010 → sector=2, dir=1, pos_count decrements by 1.
- From sector 0, apply 110 → hall_fault=1, fault_code=10, sector_valid=0; pulse clr_fault → INIT, and the next valid H gives sector_valid=1.
- 000 for 1 cycle → no fault, sector held; 111 for 2 cycles → fault_code=01.
- Set STALL_CYCLES=1000 and hold H for 1200 cycles → stall rises at cycle 1000 after the step; the next step clears stall with no period_valid.
- encoder_error_data[0]=1 during TRACK → fault_code=11. clr_fault while still high → ignored. Deassert, then clr_fault → INIT.
